approx_ha_array_pipe: RTL and testbench
=======================================

Name: approx_ha_array_pipe

Overview:
- Parametrised, pipelined successor of the fixed 8x8 approximate half-adder-array stage.
- Forms the N×N unsigned partial products and pairs rows (2k, 2k+1) into N/2 half-adder arrays.
- Each HA cell's approximation mode is selected at run time from a double-buffered, software-loadable mode table rather than fixed in RTL.
- Sits between the operand source and the downstream compressor/adder tree; valid/ready on both sides.

Parameters:
- N, 8, operand width; even, ≥4.
- CELLS, (N/2)*(N-1), derived: total HA cells; cell index c = k*(N-1)+j.
- RST_MODE, 2'b00, mode loaded into every shadow and active entry at reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  stage accepts operands.
- x  in  N  multiplicand.
- y  in  N  multiplier.
- out_valid  out  1  arrays valid.
- out_ready  in  1  downstream accepts.
- ha_b  out  (N/2)*(N-1)  bottom rows; array k at [k*(N-1) +: N-1].
- ha_t  out  (N/2)*(N+1)  top rows; array k at [k*(N+1) +: N+1].
- cfg_we  in  1  write shadow mode entry.
- cfg_addr  in  clog2(CELLS)  cell index.
- cfg_mode  in  2  mode value.
- cfg_commit  in  1  request shadow→active copy.
- cfg_busy  out  1  commit pending.

Behaviour:
- Partial products: pp[r][i] = x[r] & y[i].
- For array k: E = row 2k, O = row 2k+1.
- Cell j (0..N-2): a = pp[E][j+1] (j=0 uses pp[E][1]); b = pp[O][j].
- Per-cell mode:
  - 00 EXACT: {c,s} = a+b.
  - 01 OR_SUM: s = a|b, c = 0.
  - 10 ELIM: s = 0, c = 0.
  - 11 A_CARRY: c = a, s = 0.
- Array mapping:
  - t[0] = pp[E][0].
  - t[j+1] = s_j.
  - b[j] = c_j for j < N-2.
  - b[N-2] = pp[O][N-1].
  - t[N] = c_{N-2}.
- Bit weights: t[i] = 2^(i+2k); b[i] = 2^(i+2+2k). With all cells EXACT, the sum over all arrays equals x*y exactly.
- Pipeline: 2 stages.
  - S0 registers x, y.
  - S1 registers ha_b/ha_t, computed combinationally from S0 and the active mode table.
  - Latency 2 cycles from accept to out_valid with no stalls; throughput 1/cycle.
- Stall rules:
  - S1 advances when !out_valid | out_ready.
  - S0 advances when S1 advances or S0 is empty.
  - in_ready = S0 can advance & state==RUN.
  - Data registers hold while stalled; no bubbles are inserted when both sides are ready.
- Config:
  - cfg_we writes shadow[cfg_addr] on the clock edge; allowed in any state.
  - cfg_addr ≥ CELLS is ignored.
- Commit FSM, states RUN and DRAIN:
  - RUN + cfg_commit:
    - if S0 and S1 are both empty, copy shadow→active this edge and stay in RUN;
    - otherwise go to DRAIN.
  - DRAIN: in_ready = 0, cfg_busy = 1. Once S0 and S1 are both empty, copy shadow→active and return to RUN.
  - A transaction accepted before the commit edge always uses the old active table.
  - cfg_commit asserted while in DRAIN is absorbed; no effect.
  - A cfg_we in the same cycle as the copy lands in shadow only.
- Reset (async assert, sync release): out_valid = 0, S0 valid = 0, ha_b = 0, ha_t = 0, state = RUN, cfg_busy = 0, shadow = active = RST_MODE.
- Reset mid-operation: in-flight data is discarded and nothing is emitted after reset.

Decomposition:
- Package approx_ha_pkg:
  - mode enum: MODE_EXACT, MODE_OR_SUM, MODE_ELIM, MODE_A_CARRY;
  - function cell_idx(k, j);
  - N-derived width constants.
- Sub-module approx_ha_cell: combinational (a, b, mode) → (s, c); instantiated CELLS times via generate.

Test Plan:
- All EXACT, x=255, y=255 → weighted sum of arrays = 65025; latency 2 cycles; t[0] of array 0 = 1.
- All ELIM, x=y=255 → each array t=0x001, b=0x40; weighted total = 257*85 = 21845.
- All OR_SUM, x=y=255 → each array t=0x0FF, b=0x40; total = 511*85 = 43435.
- Random operands, back-to-back in_valid, out_ready toggling 50% → no loss or duplication; order preserved; EXACT results match x*y.
- Stream in flight, write cell 0 = ELIM, pulse cfg_commit → in_ready low and cfg_busy high until drained; earlier results exact; first later x=1, y=3 gives array-0 t[1]=0, b[0]=0.
- Assert rst_n low mid-stream and with cfg_busy=1 → out_valid=0 immediately; after release, modes = RST_MODE and state = RUN.

Source files
------------

// File: rtl/approx_ha_array_pipe_pkg.sv
// Shared types and width helpers for the pipelined approximate half-adder array.
package approx_ha_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_EXACT   = 2'b00,
        MODE_OR_SUM  = 2'b01,
        MODE_ELIM    = 2'b10,
        MODE_A_CARRY = 2'b11
    } mode_e;

    function automatic int cells_of(input int n);
        return (n / 2) * (n - 1);
    endfunction

    function automatic int ha_b_w(input int n);
        return (n / 2) * (n - 1);
    endfunction

    function automatic int ha_t_w(input int n);
        return (n / 2) * (n + 1);
    endfunction

    // Flat cell index: array k, column j.
    function automatic int cell_idx(input int k, input int j, input int n);
        return k * (n - 1) + j;
    endfunction

endpackage

// File: rtl/approx_ha_array_pipe_if.sv
// Operand-in / array-out stream bundle for approx_ha_array_pipe.
interface approx_ha_array_pipe_if #(
    parameter int N = 8
) ();
    // Both streams: a beat transfers on a rising edge where valid && ready; the
    // source holds valid and payload stable until then, ready may change freely.
    logic                                in_valid;
    logic                                in_ready;
    logic [N-1:0]                        x;
    logic [N-1:0]                        y;
    logic                                out_valid;
    logic                                out_ready;
    logic [approx_ha_pkg::ha_b_w(N)-1:0] ha_b;
    logic [approx_ha_pkg::ha_t_w(N)-1:0] ha_t;

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, ha_b, ha_t
    );

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, ha_b, ha_t
    );
endinterface

// File: rtl/approx_ha_array_pipe_cell.sv
// One run-time configurable approximate half-adder cell.
module approx_ha_cell
    import approx_ha_pkg::*;
(
    input  logic  a_i,
    input  logic  b_i,
    input  mode_e mode_i,
    output logic  s_o,
    output logic  c_o
);
    always_comb begin
        s_o = 1'b0;
        c_o = 1'b0;
        case (mode_i)
            MODE_EXACT: begin
                s_o = a_i ^ b_i;
                c_o = a_i & b_i;
            end
            MODE_OR_SUM:  s_o = a_i | b_i;
            MODE_ELIM:    ;
            MODE_A_CARRY: c_o = a_i;
            default:      ;
        endcase
    end
endmodule

// File: rtl/approx_ha_array_pipe.sv
// Two-stage N x N partial-product half-adder-array stage with a double-buffered
// per-cell mode table; commits are deferred until the pipeline has drained.
module approx_ha_array_pipe
    import approx_ha_pkg::*;
#(
    parameter int                 N        = 8,
    parameter logic [MODE_W-1:0]  RST_MODE = 2'b00
) (
    input  logic                              clk,
    input  logic                              rst_n,
    approx_ha_array_pipe_if.slave             bus,
    input  logic                              cfg_we,
    input  logic [$clog2(cells_of(N))-1:0]    cfg_addr,
    input  logic [MODE_W-1:0]                 cfg_mode,
    input  logic                              cfg_commit,
    output logic                              cfg_busy,
    output logic [0:0]                        dbg_state_o
);
    localparam int CELLS = cells_of(N);
    localparam int BW    = ha_b_w(N);
    localparam int TW    = ha_t_w(N);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          copy_tbl;
    logic          s0_valid_q;
    logic [N-1:0]  x_q, y_q;
    logic          out_valid_q;
    logic [BW-1:0] ha_b_q, ha_b_c;
    logic [TW-1:0] ha_t_q, ha_t_c;
    mode_e         shadow_q [CELLS];
    mode_e         active_q [CELLS];
    logic [CELLS-1:0] s_w, c_w;
    logic          s1_adv, s0_adv, accept, pipe_empty;

    assign s1_adv       = !out_valid_q || bus.out_ready;
    assign s0_adv       = s1_adv || !s0_valid_q;
    assign bus.in_ready = s0_adv && (state_q == ST_RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign pipe_empty   = !s0_valid_q && !out_valid_q;

    assign bus.out_valid = out_valid_q;
    assign bus.ha_b      = ha_b_q;
    assign bus.ha_t      = ha_t_q;
    assign cfg_busy      = (state_q == ST_DRAIN);
    assign dbg_state_o   = state_q;

    // Array k pairs rows 2k (E) and 2k+1 (O); cell j adds pp[E][j+1] and pp[O][j].
    for (genvar k = 0; k < N / 2; k++) begin : g_arr
        for (genvar j = 0; j < N - 1; j++) begin : g_cell
            localparam int C = cell_idx(k, j, N);
            approx_ha_cell u_cell (
                .a_i   (x_q[2*k] & y_q[j+1]),
                .b_i   (x_q[2*k+1] & y_q[j]),
                .mode_i(active_q[C]),
                .s_o   (s_w[C]),
                .c_o   (c_w[C])
            );
            assign ha_t_c[k*(N+1)+j+1] = s_w[C];
            if (j < N - 2) begin : g_b
                assign ha_b_c[k*(N-1)+j] = c_w[C];
            end
        end
        assign ha_t_c[k*(N+1)]     = x_q[2*k] & y_q[0];
        assign ha_t_c[k*(N+1)+N]   = c_w[cell_idx(k, N - 2, N)];
        assign ha_b_c[k*(N-1)+N-2] = x_q[2*k+1] & y_q[N-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            ha_b_q      <= '0;
            ha_t_q      <= '0;
        end else begin
            if (s0_adv) begin
                s0_valid_q <= accept;
                if (accept) begin
                    x_q <= bus.x;
                    y_q <= bus.y;
                end
            end
            if (s1_adv) begin
                out_valid_q <= s0_valid_q;
                if (s0_valid_q) begin
                    ha_b_q <= ha_b_c;
                    ha_t_q <= ha_t_c;
                end
            end
        end
    end

    // The active table only changes with nothing in flight, so every beat sees one table.
    always_comb begin
        state_d  = state_q;
        copy_tbl = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_commit) begin
                    if (pipe_empty) copy_tbl = 1'b1;
                    else            state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    copy_tbl = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            for (int i = 0; i < CELLS; i++) begin
                shadow_q[i] <= mode_e'(RST_MODE);
                active_q[i] <= mode_e'(RST_MODE);
            end
        end else begin
            state_q <= state_d;
            if (copy_tbl) begin
                for (int i = 0; i < CELLS; i++) active_q[i] <= shadow_q[i];
            end
            if (cfg_we && (int'(cfg_addr) < CELLS)) begin
                shadow_q[cfg_addr] <= mode_e'(cfg_mode);
            end
        end
    end
endmodule

// File: tb/tb_approx_ha_array_pipe.sv
// Scoreboard bench for approx_ha_array_pipe: directed operands, expected queue, monitor.
module tb_approx_ha_array_pipe;
    import approx_ha_pkg::*;

    localparam int N  = 8;
    localparam int BW = 28;
    localparam int TW = 36;
    localparam int SW = 20;
    localparam int W  = 1 + BW + TW + SW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    approx_ha_array_pipe_if #(.N(N)) bus ();
    logic       cfg_we, cfg_commit, cfg_busy;
    logic [4:0] cfg_addr;
    logic [1:0] cfg_mode;
    logic [0:0] dbg_state;

    approx_ha_array_pipe #(.N(N), .RST_MODE(2'b00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mode   (cfg_mode),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .dbg_state_o(dbg_state)
    );

    // Entry: {check_arrays, ha_b, ha_t, weighted_sum}
    logic [W-1:0] exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    logic or_rand = 1'b0;
    logic or_fix  = 1'b1;

    function automatic logic [W-1:0] mk(input logic h, input logic [BW-1:0] b,
                                        input logic [TW-1:0] t, input int s);
        return {h, b, t, SW'(s)};
    endfunction

    // Weighted value of the arrays: t[i] at 2^(i+2k), b[i] at 2^(i+2+2k).
    function automatic int wsum(input logic [BW-1:0] b, input logic [TW-1:0] t);
        int s = 0;
        for (int k = 0; k < N / 2; k++) begin
            for (int i = 0; i < N + 1; i++) if (t[k*(N+1)+i]) s += 1 << (i + 2*k);
            for (int i = 0; i < N - 1; i++) if (b[k*(N-1)+i]) s += 1 << (i + 2 + 2*k);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Downstream ready changes just after posedge so it is stable at every negedge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_fix;
        end
    end

    // Monitor: a beat seen valid && ready at negedge transfers on the next posedge.
    initial begin
        logic [W-1:0]  e;
        logic          h;
        logic [BW-1:0] eb;
        logic [TW-1:0] et;
        logic [SW-1:0] es;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got b=%0h t=%0h expected none", bus.ha_b, bus.ha_t);
                end else begin
                    e = exp_q.pop_front();
                    {h, eb, et, es} = e;
                    check("weighted_sum", 128'(wsum(bus.ha_b, bus.ha_t)), 128'(es));
                    if (h) begin
                        check("ha_b", 128'(bus.ha_b), 128'(eb));
                        check("ha_t", 128'(bus.ha_t), 128'(et));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_ready(input logic rnd, input logic val);
        or_rand = rnd;
        or_fix  = val;
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic [W-1:0] e);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x = xv;
        bus.y = yv;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            timeout_fail("send_in_ready");
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic write_cfg(input logic [4:0] a, input logic [1:0] m);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_mode = m;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (cfg_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (cfg_busy) timeout_fail("cfg_busy_clear");
    endtask

    task automatic commit_cfg();
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        wait_not_busy();
    endtask

    task automatic set_all(input logic [1:0] m);
        for (int c = 0; c < 28; c++) write_cfg(5'(c), m);
        commit_cfg();
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) timeout_fail("drain_queue");
    endtask

    initial begin
        int           n;
        logic         seen;
        logic [7:0]   xv, yv;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        cfg_addr = '0;
        cfg_mode = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_ha_b", 128'(bus.ha_b), 128'(0));
        check("rst_ha_t", 128'(bus.ha_t), 128'(0));
        check("rst_cfg_busy", 128'(cfg_busy), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Out-of-range address must not disturb any cell.
        write_cfg(5'd31, MODE_ELIM);
        commit_cfg();

        // All EXACT, 255*255 with latency measured from the accept edge.
        send(8'd255, 8'd255, mk(1'b1, {4{7'h7F}}, {4{9'h101}}, 65025));
        idle();
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 128'(n), 128'(2));
        wait_empty();

        set_all(MODE_ELIM);
        send(8'd255, 8'd255, mk(1'b1, {4{7'h40}}, {4{9'h001}}, 21845));
        idle();
        wait_empty();

        set_all(MODE_OR_SUM);
        send(8'd255, 8'd255, mk(1'b1, {4{7'h40}}, {4{9'h0FF}}, 43435));
        idle();
        wait_empty();

        // Random EXACT stream with downstream ready toggling.
        set_all(MODE_EXACT);
        set_ready(1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            xv = 8'($urandom_range(0, 255));
            yv = 8'($urandom_range(0, 255));
            send(xv, yv, mk(1'b0, '0, '0, int'(xv) * int'(yv)));
        end
        send(8'd0, 8'd0, mk(1'b1, '0, '0, 0));
        send(8'd1, 8'd3, mk(1'b1, '0, 36'h3, 3));
        idle();
        wait_empty();

        // Commit with beats in flight: must drain before the new table applies.
        set_ready(1'b0, 1'b0);
        send(8'd17, 8'd29, mk(1'b0, '0, '0, 17 * 29));
        send(8'd200, 8'd3, mk(1'b0, '0, '0, 600));
        idle();
        write_cfg(5'd0, MODE_ELIM);
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("drain_busy", 128'(cfg_busy), 128'(1));
        check("drain_in_ready", 128'(bus.in_ready), 128'(0));
        check("drain_state", 128'(dbg_state), 128'(1));
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("drain_busy_hold", 128'(cfg_busy), 128'(1));
        set_ready(1'b0, 1'b1);
        wait_not_busy();
        check("drained_before_copy", 128'(exp_q.size()), 128'(0));
        send(8'd1, 8'd3, mk(1'b1, '0, 36'h1, 1));
        idle();
        wait_empty();

        // Reset while a commit is pending with beats stalled in the pipe.
        set_ready(1'b0, 1'b0);
        send(8'd9, 8'd9, mk(1'b0, '0, '0, 81));
        send(8'd7, 8'd5, mk(1'b0, '0, '0, 35));
        idle();
        write_cfg(5'd0, MODE_ELIM);
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("pre_rst_busy", 128'(cfg_busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_busy", 128'(cfg_busy), 128'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_state", 128'(dbg_state), 128'(0));
        set_ready(1'b0, 1'b1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("post_rst_no_emit", 128'(seen), 128'(0));
        commit_cfg();
        send(8'd1, 8'd3, mk(1'b1, '0, 36'h3, 3));
        idle();
        wait_empty();

        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
